ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_if.sv | 26 ++
 rtl/ex_div.sv | 161 ++++++++++++++++
 tb/tb_ex_div.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Request/response bundle between the execute stage and the ex_div divider.
// The execute stage holds the master side and the divider holds the slave side.
interface ex_div_if;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  waddr_i;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  waddr_o;
    logic        reg_we;

    modport master (
        output start, div_op, dividend, divisor, waddr_i, flush,
        input  stall_req, busy, done, result, waddr_o, reg_we
    );

    modport slave (
        input  start, div_op, dividend, divisor, waddr_i, flush,
        output stall_req, busy, done, result, waddr_o, reg_we
    );
endinterface

// File: rtl/ex_div.sv
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Divide-by-zero and signed overflow bypass the iteration and complete in a single cycle.
module ex_div (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        neg_if = neg ? (32'd0 - v) : v;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [4:0]  cnt_r;
    logic        rem_sel_r;
    logic [4:0]  waddr_r;
    logic [31:0] quot_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic [31:0] result_r;
    logic [4:0]  waddr_o_r;

    logic        start_ok_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic [32:0] shifted_s;
    logic [32:0] trial_s;
    logic [31:0] quot_nxt_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] final_s;

    // Request decode, special-case detection and the single restoring iteration
    always_comb begin
        start_ok_s = bus.start && !bus.flush;
        a_neg_s    = !bus.div_op[0] && bus.dividend[31];
        b_neg_s    = !bus.div_op[0] && bus.divisor[31];
        special_s  = 1'b0;
        special_res_s = 32'd0;
        if (bus.divisor == 32'd0) begin
            special_s     = 1'b1;
            special_res_s = bus.div_op[1] ? bus.dividend : 32'hFFFF_FFFF;
        end else if (!bus.div_op[0] && (bus.dividend == 32'h8000_0000)
                     && (bus.divisor == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_res_s = bus.div_op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_res_s = 32'd0;
        end

        // The shifted partial remainder can reach 33 bits, so the trial subtract is 33 wide
        shifted_s = {rem_r, quot_r[31]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (!trial_s[32]) begin
            rem_nxt_s  = trial_s[31:0];
            quot_nxt_s = {quot_r[30:0], 1'b1};
        end else begin
            rem_nxt_s  = shifted_s[31:0];
            quot_nxt_s = {quot_r[30:0], 1'b0};
        end
        final_s = rem_sel_r ? neg_if(neg_r_r, rem_nxt_s) : neg_if(neg_q_r, quot_nxt_s);
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = special_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == 5'd31) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State and iteration counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s == ST_CALC && state_r == ST_CALC) begin
                cnt_r <= cnt_r + 5'd1;
            end else begin
                cnt_r <= 5'd0;
            end
        end
    end

    // Operand capture at start, then shift/subtract while iterating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_sel_r <= 1'b0;
            waddr_r   <= 5'd0;
            quot_r    <= 32'd0;
            rem_r     <= 32'd0;
            dvs_r     <= 32'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
        end else if (state_r == ST_IDLE && start_ok_s) begin
            rem_sel_r <= bus.div_op[1];
            waddr_r   <= bus.waddr_i;
            quot_r    <= neg_if(a_neg_s, bus.dividend);
            rem_r     <= 32'd0;
            dvs_r     <= neg_if(b_neg_s, bus.divisor);
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
        end else if (state_r == ST_CALC) begin
            quot_r <= quot_nxt_s;
            rem_r  <= rem_nxt_s;
        end else begin
            quot_r <= quot_r;
            rem_r  <= rem_r;
        end
    end

    // Result and write address are only non-zero for the single DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r  <= 32'd0;
            waddr_o_r <= 5'd0;
        end else if (state_nxt_s == ST_DONE) begin
            result_r  <= (state_r == ST_IDLE) ? special_res_s : final_s;
            waddr_o_r <= (state_r == ST_IDLE) ? bus.waddr_i : waddr_r;
        end else begin
            result_r  <= 32'd0;
            waddr_o_r <= 5'd0;
        end
    end

    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.done      = (state_r == ST_DONE);
    assign bus.reg_we    = (state_r == ST_DONE);
    assign bus.result    = result_r;
    assign bus.waddr_o   = waddr_o_r;
    assign bus.stall_req = rst && (((state_r == ST_IDLE) && start_ok_s) || (state_r == ST_CALC));
endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned results,
// divide-by-zero, overflow, flush and asynchronous reset mid-operation.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;

    ex_div_if bus();

    ex_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and watches 40 cycles after the start edge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] w, input int hold,
                          output int lat, output logic [31:0] res, output logic [4:0] wa,
                          output int pulses, output int stall_late, output int leak,
                          output logic stall0);
        bus.div_op = op; bus.dividend = a; bus.divisor = b; bus.waddr_i = w;
        bus.start = 1'b1;
        #1;
        stall0 = bus.stall_req;
        tick;
        bus.dividend = 32'd9; bus.divisor = 32'd3; bus.waddr_i = 5'd31;
        lat = 0; res = 32'd0; wa = 5'd0; pulses = 0; stall_late = 0; leak = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n > hold) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat == 0) begin lat = n; res = bus.result; wa = bus.waddr_o; end
            end else if (bus.result !== 32'd0 || bus.waddr_o !== 5'd0) begin
                leak++;
            end
            if (bus.reg_we !== bus.done) leak++;
            if (bus.stall_req === 1'b1) stall_late++;
            tick;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.start = 1'b1; bus.flush = 1'b0; bus.div_op = 2'b01;
        bus.dividend = 32'd10; bus.divisor = 32'd2; bus.waddr_i = 5'd7;
        #12;
        n_checks++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b reg_we=%b expected 0/0/0", bus.busy, bus.done, bus.reg_we); end
        n_checks++; if (bus.result !== 32'd0 || bus.waddr_o !== 5'd0) begin
            n_fail++; $display("FAIL reset_data: result=%h waddr_o=%0d expected 0/0", bus.result, bus.waddr_o); end
        bus.start = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_divu;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        run_op(2'b01, 32'd100, 32'd7, 5'd5, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL divu_stall_start: got %b expected 1", s0); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %0d expected 14", res); end
        n_checks++; if (wa !== 5'd5) begin n_fail++; $display("FAIL divu_waddr: got %0d expected 5", wa); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL divu_pulses: got %0d expected 1", pulses); end
        n_checks++; if (leak !== 0) begin n_fail++; $display("FAIL divu_idle_outputs: got %0d bad cycles expected 0", leak); end
    endtask

    task automatic test_signed;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        logic [1:0]  ops [5]  = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b11};
        logic [31:0] as [5]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20, 32'd20, 32'hFFFF_FFFF};
        logic [31:0] bs [5]   = '{32'd2, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd16};
        logic [31:0] exps [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd2, 32'd15};
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 5'(i + 1), 0, lat, res, wa, pulses, sl, leak, s0);
            n_checks++; if (res !== exps[i] || lat !== 33) begin
                n_fail++; $display("FAIL signed_vec%0d: result=%h lat=%0d expected %h lat 33", i, res, lat, exps[i]); end
        end
    endtask

    task automatic test_div_zero;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        run_op(2'b01, 32'h1234_5678, 32'd0, 5'd3, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) begin
            n_fail++; $display("FAIL divz_divu: result=%h lat=%0d expected ffffffff lat 1", res, lat); end
        n_checks++; if (sl !== 0 || wa !== 5'd3) begin
            n_fail++; $display("FAIL divz_stall_waddr: stall cycles=%0d waddr=%0d expected 0 and 3", sl, wa); end
        run_op(2'b11, 32'h1234_5678, 32'd0, 5'd4, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'h1234_5678 || lat !== 1 || pulses !== 1) begin
            n_fail++; $display("FAIL divz_remu: result=%h lat=%0d pulses=%0d expected 12345678 lat 1 pulses 1", res, lat, pulses); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd4, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'hFFFF_FFF9 || lat !== 1) begin
            n_fail++; $display("FAIL divz_rem: result=%h lat=%0d expected fffffff9 lat 1", res, lat); end
    endtask

    task automatic test_overflow;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'h8000_0000 || lat !== 1) begin
            n_fail++; $display("FAIL ovf_div: result=%h lat=%0d expected 80000000 lat 1", res, lat); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'd0 || lat !== 1 || pulses !== 1 || wa !== 5'd8) begin
            n_fail++; $display("FAIL ovf_rem: result=%h lat=%0d pulses=%0d waddr=%0d expected 0 lat 1 pulses 1 waddr 8", res, lat, pulses, wa); end
    endtask

    task automatic test_flush;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        int stray = 0;
        bus.div_op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.waddr_i = 5'd2;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (10) tick;
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b done=%b expected 0/0", bus.busy, bus.done); end
        for (int i = 0; i < 2; i++) begin
            if (bus.done !== 1'b0) stray++;
            tick;
        end
        run_op(2'b11, 32'd50, 32'd8, 5'd9, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'd2 || lat !== 33 || pulses !== 1 || stray !== 0) begin
            n_fail++; $display("FAIL flush_restart: result=%0d lat=%0d pulses=%0d stray=%0d expected 2 33 1 0", res, lat, pulses, stray); end
        bus.div_op = 2'b01; bus.dividend = 32'd40; bus.divisor = 32'd5;
        bus.start = 1'b1; bus.flush = 1'b1;
        tick;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL flush_start_same_cycle: busy=%b done=%b expected 0/0", bus.busy, bus.done); end
        tick;
    endtask

    task automatic test_back_to_back;
        int lat, pulses, sl, leak; logic [31:0] res; logic [4:0] wa; logic s0;
        run_op(2'b01, 32'd1000, 32'd3, 5'd12, 20, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'd333 || lat !== 33 || pulses !== 1 || wa !== 5'd12) begin
            n_fail++; $display("FAIL held_start: result=%0d lat=%0d pulses=%0d waddr=%0d expected 333 33 1 12", res, lat, pulses, wa); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13, 0, lat, res, wa, pulses, sl, leak, s0);
        n_checks++; if (res !== 32'hFFFF_FFFF || lat !== 33) begin
            n_fail++; $display("FAIL b2b_divu_max: result=%h lat=%0d expected ffffffff 33", res, lat); end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        bus.div_op = 2'b01; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.waddr_i = 5'd6;
        bus.start = 1'b1;
        tick;
        repeat (5) tick;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: busy=%b stall=%b done=%b expected 0/0/0", bus.busy, bus.stall_req, bus.done); end
        bus.start = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        n_checks++; if (pulses !== 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", pulses); end
    endtask

    initial begin
        test_reset;
        test_divu;
        test_signed;
        test_div_zero;
        test_overflow;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
